fir_sample_sequencer: RTL and testbench

// - Paces incoming audio samples into the serial FIR engine (fir_filter) so no new sample is issued mid-computation.
// - A new sample during a MAC sweep would restart the engine and corrupt the result.
// - Buffers samples in a small FIFO; issues one sample per engine completion; returns each filtered result with a 1-cycle valid.
// - Sits between the audio sample source and fir_filter; owns the engine's valid_in/data_ready handshake.

---
 rtl/fir_sample_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_fir_sample_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: queues source samples and issues them to the serial FIR engine one per completion.
// Latency: issue 1 edge after the FIFO write (when idle); result valid 1 edge after the accepted fir_ready_in.
// Backpressure: FIFO_DEPTH-entry buffer; a push while full with no same-cycle pop is dropped and counted.
// Optional: define FIR_WATCHDOG_EN to abandon a sample left in WAIT for TIMEOUT cycles.

// Generic circular-buffer FIFO; the caller gates push/pop against full/empty.
module fir_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  // storage write at the tail; never read while empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // pointers wrap on their own because DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

module fir_sample_sequencer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid_in,
  output logic             fifo_full_out,
  output logic [WIDTH-1:0] fir_audio_out,
  output logic             fir_valid_out,
  input  logic [WIDTH-1:0] fir_result_in,
  input  logic             fir_ready_in,
  output logic [WIDTH-1:0] audio_out,
  output logic             audio_valid_out,
  output logic             busy_out,
  output logic [15:0]      overflow_count_out,
  output logic             timeout_out
);
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             push;
  logic             pop;
  logic             drop;
  logic             complete;
  logic             expire;
  logic             wd_hit;
  logic [WIDTH-1:0] head;
  logic             empty;
  logic             full;

  // the pointer wrap needs a power-of-two depth; the watchdog must outlast the engine
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_sample_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT <= 34) begin : g_bad_timeout
    $error("fir_sample_sequencer: TIMEOUT must exceed the engine latency");
  end

  fir_seq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_in),
    .rst    (rst_in),
    .push   (push),
    .wr_dat (sample_in),
    .pop    (pop),
    .head   (head),
    .empty  (empty),
    .full   (full)
  );

  // a full FIFO still accepts a sample on the cycle its head leaves
  assign push          = sample_valid_in && (!full || pop);
  assign drop          = sample_valid_in && full && !pop;
  assign fifo_full_out = full;
  assign busy_out      = (state == S_WAIT);

`ifdef FIR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_cnt;

  // watchdog restarts on every issue and advances while the engine is outstanding
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wd_cnt <= '0;
    end else if (pop) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_hit = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign wd_hit = 1'b0;
`endif

  // issue from IDLE when data is queued; leave WAIT on a fresh completion, else on watchdog expiry
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // data_ready seen alongside our own valid pulse is left over from the previous sweep
        if (fir_ready_in && !fir_valid_out) begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end else if (wd_hit) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // engine-facing issue register: one valid pulse per popped sample
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fir_valid_out <= 1'b0;
      fir_audio_out <= '0;
    end else begin
      fir_valid_out <= pop;
      if (pop) begin
        fir_audio_out <= head;
      end
    end
  end

  // result capture, watchdog pulse and saturating drop counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      audio_valid_out    <= 1'b0;
      audio_out          <= '0;
      timeout_out        <= 1'b0;
      overflow_count_out <= '0;
    end else begin
      audio_valid_out <= complete;
      timeout_out     <= expire;
      if (complete) begin
        audio_out <= fir_result_in;
      end
      if (drop && overflow_count_out != 16'hFFFF) begin
        overflow_count_out <= overflow_count_out + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: queue-based reference model compared every cycle,
// a stub FIR engine with programmable latency, and directed vectors with literal expectations.
module tb_fir_sample_sequencer;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid_in;
  logic             fifo_full_out;
  logic [WIDTH-1:0] fir_audio_out;
  logic             fir_valid_out;
  logic [WIDTH-1:0] fir_result_in;
  logic             fir_ready_in;
  logic [WIDTH-1:0] audio_out;
  logic             audio_valid_out;
  logic             busy_out;
  logic [15:0]      overflow_count_out;
  logic             timeout_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fir_sample_sequencer #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .sample_in          (sample_in),
    .sample_valid_in    (sample_valid_in),
    .fifo_full_out      (fifo_full_out),
    .fir_audio_out      (fir_audio_out),
    .fir_valid_out      (fir_valid_out),
    .fir_result_in      (fir_result_in),
    .fir_ready_in       (fir_ready_in),
    .audio_out          (audio_out),
    .audio_valid_out    (audio_valid_out),
    .busy_out           (busy_out),
    .overflow_count_out (overflow_count_out),
    .timeout_out        (timeout_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  // Reference model: a sample queue plus "which edge was the engine started on".
  int          m_q[$];
  bit          m_busy = 0;
  int          m_issue_edge = 0;
  int          edge_n = 0;
  logic [7:0]  e_fa = 0, e_a = 0;
  bit          e_fv = 0, e_av = 0, e_to = 0;
  int          e_ovf = 0;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_q.delete();
      m_busy = 0; e_fa = 0; e_a = 0; e_fv = 0; e_av = 0; e_to = 0; e_ovf = 0;
    end else begin
      edge_n++;
      e_fv = 0; e_av = 0; e_to = 0;
      if (m_busy) begin
        // the first edge after an issue sees a stale ready; only later ones count
        if (fir_ready_in && edge_n >= m_issue_edge + 2) begin
          e_a = fir_result_in; e_av = 1; m_busy = 0;
        end
`ifdef FIR_WATCHDOG_EN
        else if (edge_n == m_issue_edge + TIMEOUT) begin
          e_to = 1; m_busy = 0;
        end
`endif
      end else if (m_q.size() > 0) begin
        e_fa = 8'(m_q.pop_front()); e_fv = 1; m_busy = 1; m_issue_edge = edge_n;
      end
      if (sample_valid_in) begin
        if (m_q.size() < DEPTH) m_q.push_back(int'(sample_in));
        else if (e_ovf < 65535) e_ovf++;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk_in) begin
    chk("fir_valid_out", fir_valid_out, e_fv);
    chk("fir_audio_out", fir_audio_out, e_fa);
    chk("audio_valid_out", audio_valid_out, e_av);
    chk("audio_out", audio_out, e_a);
    chk("busy_out", busy_out, m_busy);
    chk("fifo_full_out", fifo_full_out, m_q.size() == DEPTH);
    chk("overflow_count_out", overflow_count_out, e_ovf);
    chk("timeout_out", timeout_out, e_to);
  end

  // event log for the directed checks
  int iss_q[$], iss_c[$], res_q[$], res_c[$], to_c[$];
  always @(negedge clk_in) begin
    if (fir_valid_out === 1'b1)   begin iss_q.push_back(int'(fir_audio_out)); iss_c.push_back(cyc); end
    if (audio_valid_out === 1'b1) begin res_q.push_back(int'(audio_out)); res_c.push_back(cyc); end
    if (timeout_out === 1'b1)     to_c.push_back(cyc);
  end

  // stub engine: result = sample/2, data_ready sampled eng_lat edges after the issue edge
  int                eng_lat = 34;
  bit                eng_stale = 0;
  bit                eng_pend = 0;
  int                eng_issue = 0;
  logic signed [7:0] eng_data = 0;
  initial begin
    fir_ready_in = 1'b0;
    fir_result_in = '0;
    forever begin
      @(negedge clk_in); #1;
      fir_ready_in = 1'b0;
      if (fir_valid_out) begin
        eng_pend = 1; eng_issue = cyc; eng_data = fir_audio_out;
        if (eng_stale) fir_ready_in = 1'b1;
      end else if (eng_pend && cyc >= eng_issue + eng_lat - 1) begin
        fir_ready_in = 1'b1; fir_result_in = eng_data >>> 1; eng_pend = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk_in);
    sample_valid_in = v;
    sample_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic clr();
    iss_q.delete(); iss_c.delete(); res_q.delete(); res_c.delete(); to_c.delete();
  endtask

  int push_cyc;
  int exp_iss[6] = '{40, 41, 42, 43, 44, 47};
  int exp_res[6] = '{20, 20, 21, 21, 22, 23};

  initial begin
    rst_in = 1'b1; sample_valid_in = 1'b0; sample_in = '0;
    idle(3);
    chk("rst_fir_valid", fir_valid_out, 0);
    chk("rst_audio_valid", audio_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_full", fifo_full_out, 0);
    chk("rst_overflow", overflow_count_out, 0);
    chk("rst_timeout", timeout_out, 0);
    rst_in = 1'b0;
    idle(2);

    // single sample, 34-cycle engine
    clr();
    drive(1, 8'd50); push_cyc = cyc + 1;
    drive(0, 8'd0);
    idle(45);
    chk("t1_issue_count", iss_q.size(), 1);
    chk("t1_issue_val", qget(iss_q, 0), 50);
    chk("t1_issue_lat", qget(iss_c, 0) - push_cyc, 1);
    chk("t1_result_count", res_q.size(), 1);
    chk("t1_result_val", qget(res_q, 0), 25);
    chk("t1_result_lat", qget(res_c, 0) - qget(iss_c, 0), 34);

    // burst 1..4 on consecutive cycles, short engine
    eng_lat = 3; clr();
    for (int i = 1; i <= 4; i++) drive(1, 8'(i));
    drive(0, 8'd0);
    idle(30);
    chk("t2_issue_count", iss_q.size(), 4);
    chk("t2_result_count", res_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_issue_val", qget(iss_q, i), i + 1);
      chk("t2_result_val", qget(res_q, i), (i + 1) / 2);
    end
    chk("t2_issue_gap", qget(iss_c, 1) - qget(iss_c, 0), 4);
    chk("t2_overflow", overflow_count_out, 0);

    // stalled engine: six pushes into a four-entry FIFO
    eng_lat = 1000; clr();
    drive(1, 8'd40);
    drive(0, 8'd0);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (i == 3) chk("t3_three_not_full", fifo_full_out, 0);
      if (i == 4) chk("t3_four_full", fifo_full_out, 1);
      sample_valid_in = 1'b1; sample_in = 8'(41 + i);
    end
    @(negedge clk_in); sample_valid_in = 1'b0;
    chk("t3_full", fifo_full_out, 1);
    chk("t3_overflow", overflow_count_out, 2);

    // release the engine, then push exactly on the pop edge with the FIFO full
    @(negedge clk_in); eng_lat = 2;
    @(negedge clk_in); sample_valid_in = 1'b1; sample_in = 8'd47; eng_lat = 3;
    @(negedge clk_in); sample_valid_in = 1'b0;
    chk("t4_still_full", fifo_full_out, 1);
    chk("t4_overflow_same", overflow_count_out, 2);
    chk("t4_pop_valid", fir_valid_out, 1);
    chk("t4_pop_val", fir_audio_out, 41);
    idle(40);
    chk("t4_issue_count", iss_q.size(), 6);
    chk("t4_result_count", res_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t4_issue_val", qget(iss_q, i), exp_iss[i]);
      chk("t4_result_val", qget(res_q, i), exp_res[i]);
    end

    // reset ten cycles into WAIT
    eng_lat = 20; clr();
    drive(1, 8'd60);
    drive(0, 8'd0);
    idle(10);
    @(negedge clk_in); #2 rst_in = 1'b1;
    #1;
    chk("t5_busy", busy_out, 0);
    chk("t5_fir_audio", fir_audio_out, 0);
    chk("t5_audio", audio_out, 0);
    chk("t5_overflow", overflow_count_out, 0);
    chk("t5_full", fifo_full_out, 0);
    @(negedge clk_in); #2 rst_in = 1'b0;
    idle(25);
    chk("t5_no_result", res_q.size(), 0);
    chk("t5_issue_count", iss_q.size(), 1);

    // negative sample with a stale ready on the issue cycle
    eng_lat = 3; eng_stale = 1; clr();
    drive(1, 8'h9C);
    drive(0, 8'd0);
    idle(12);
    eng_stale = 0;
    chk("t6_issue_val", qget(iss_q, 0), 8'h9C);
    chk("t6_result_count", res_q.size(), 1);
    chk("t6_result_val", qget(res_q, 0), 8'hCE);
    chk("t6_result_lat", qget(res_c, 0) - qget(iss_c, 0), 3);

    // engine that never answers
    eng_lat = 1000; clr();
    drive(1, 8'd70);
    drive(1, 8'd71);
    drive(0, 8'd0);
    idle(75);
`ifdef FIR_WATCHDOG_EN
    chk("t7_timeout_count", to_c.size(), 1);
    chk("t7_timeout_lat", qget(to_c, 0) - qget(iss_c, 0), TIMEOUT);
    chk("t7_issue_count", iss_q.size(), 2);
    chk("t7_next_issue", qget(iss_q, 1), 71);
    chk("t7_next_issue_lat", qget(iss_c, 1) - qget(to_c, 0), 1);
    chk("t7_no_result", res_q.size(), 0);
    eng_lat = 3;
    idle(10);
    chk("t7_result_count", res_q.size(), 1);
    chk("t7_result_val", qget(res_q, 0), 35);
`else
    chk("t7_busy_hold", busy_out, 1);
    chk("t7_no_timeout", to_c.size(), 0);
    chk("t7_issue_count", iss_q.size(), 1);
    chk("t7_no_result", res_q.size(), 0);
    eng_lat = 3;
    idle(20);
    chk("t7_issue_count_after", iss_q.size(), 2);
    chk("t7_result_count", res_q.size(), 2);
    chk("t7_result_val0", qget(res_q, 0), 35);
    chk("t7_result_val1", qget(res_q, 1), 35);
`endif
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
